wri_red: RTL and testbench
==========================

# wri_red

Small addressable storage block: a register file of `DEPTH` entries, each `WIDTH` bits wide, with one shared read/write port selected by `RW`. It serves as a local scratch/configuration store beside control logic. The default configuration is 4 entries × 1 bit, addressed by a 2-bit `ADDR`.

## Interface
Parameters:
- `WIDTH`, default 1: data bits per entry (`IN`, `OUT`, storage).
- `DEPTH`, default 4: number of entries; must be a power of two and ≥ 2.
- `AW`, default `$clog2(DEPTH)` = 2: address width (derived, not overridden).

Ports:
- `CLK`  input  1  single clock; all state updates on its rising edge.
- `RST_N`  input  1  reset, synchronous and active-low (sampled on rising `CLK`).
- `ADDR`  input  `AW`  entry select for both read and write.
- `IN`  input  `WIDTH`  write data.
- `RW`  input  1  operation select: 1 = write, 0 = read.
- `OUT`  output  `WIDTH`  registered read data.

## Operation
- Storage: `mem[0..DEPTH-1]`, each `WIDTH` bits, held in flops (no RAM macro).
- On a rising edge with `RST_N` = 0:
  - all `mem` entries are cleared to 0;
  - `OUT` is cleared to 0;
  - `RW`, `ADDR` and `IN` are ignored.
- On a rising edge with `RST_N` = 1 and `RW` = 1 (write): `mem[ADDR] <= IN`. `OUT` holds its previous value.
- On a rising edge with `RST_N` = 1 and `RW` = 0 (read): `OUT <= mem[ADDR]`, using the contents before that edge. `mem` is unchanged.
- Only one operation happens per cycle; no simultaneous read and write.
- `ADDR` is always in range, because `DEPTH` = 2^`AW`. No out-of-range handling is required.
- `X` on inputs while `RST_N` = 0 must not propagate into state.

## Timing
- Write latency: the entry is updated at the edge where `RW` = 1 is sampled. A read of the same address issued on the next cycle returns the new value.
- Read latency: 1 cycle. `OUT` becomes valid after the edge at which `RW` = 0 and `ADDR` are sampled, and stays stable until the next read edge or reset.
- Back-to-back write then read of the same address: `OUT` shows the written data one edge after the read is sampled.
- Reset in the middle of a sequence: the edge with `RST_N` low takes priority over any write or read. The first edge after `RST_N` rises behaves normally.
- There is no combinational path from any input to `OUT`.

## Structure
- Shared package `wri_red_pkg`:
  - defaults `WRI_RED_WIDTH` = 1 and `WRI_RED_DEPTH` = 4;
  - constants `RW_READ` = 1'b0 and `RW_WRITE` = 1'b1.
- One natural sub-module, `wri_red_cell`: a single `WIDTH`-bit entry with synchronous active-low clear and a write enable. It is instantiated `DEPTH` times by a generate loop.
- The top level holds:
  - the address decoder (one-hot write enables, gated by `RW`);
  - the read mux;
  - the `OUT` register.

## Test plan
1. Reset: hold `RST_N` = 0 for 2 edges, then read addresses 0–3 → `OUT` = 0 for every address, one cycle after each read.
2. Write/read entry 0: `ADDR` = 0, `IN` = 1, `RW` = 1 for one edge, then `RW` = 0 → `OUT` = 1 after the read edge. During the write edge, `OUT` keeps its prior value (0).
3. Write/read entry 1: `ADDR` = 1, `IN` = 0, `RW` = 1, then `RW` = 0 → `OUT` = 0. A subsequent read of `ADDR` = 0 → `OUT` = 1, showing entries are independent.
4. All entries: write pattern 1, 0, 1, 1 to addresses 0–3, then read 3, 2, 1, 0 → `OUT` = 1, 1, 0, 1.
5. Reset mid-operation: after step 4, assert `RST_N` = 0 on an edge with `RW` = 1, `ADDR` = 2, `IN` = 1 → write suppressed, all entries 0. Reading address 0 → `OUT` = 0.
6. Parameter check: `WIDTH` = 8, `DEPTH` = 8 (`AW` = 3); write 8'hA5 to address 7, read it → `OUT` = 8'hA5. Reading address 6 → `OUT` = 8'h00.

Source files
------------

// File: rtl/wri_red_pkg.sv
// Shared defaults and operation encodings for the wri_red register file.
package wri_red_pkg;
    localparam int WRI_RED_WIDTH = 1;
    localparam int WRI_RED_DEPTH = 4;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/wri_red_cell.sv
// One storage entry: WIDTH flops with synchronous active-low clear and write enable.
module wri_red_cell
    import wri_red_pkg::*;
#(
    parameter int WIDTH = WRI_RED_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Q <= '0;
        end else if (WE) begin
            Q <= D;
        end
    end
endmodule

// File: rtl/wri_red.sv
// Flop-based register file with one shared read/write port and registered read data.
module wri_red
    import wri_red_pkg::*;
#(
    parameter  int WIDTH = WRI_RED_WIDTH,
    parameter  int DEPTH = WRI_RED_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [AW-1:0]    ADDR,
    input  logic [WIDTH-1:0] IN,
    input  logic             RW,
    output logic [WIDTH-1:0] OUT
);
    logic [DEPTH-1:0]            wr_en;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [WIDTH-1:0]            rd_data;

    // One-hot write decode; no enable is raised on a read cycle.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = (RW == RW_WRITE) && (ADDR == AW'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        wri_red_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .CLK   (CLK),
            .RST_N (RST_N),
            .WE    (wr_en[g]),
            .D     (IN),
            .Q     (mem[g])
        );
    end

    assign rd_data = mem[ADDR];

    // OUT only moves on read edges, so it holds across writes.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OUT <= '0;
        end else if (RW == RW_READ) begin
            OUT <= rd_data;
        end
    end
endmodule

// File: tb/tb_wri_red.sv
// Directed bench for wri_red: default 4x1 instance plus an 8x8 instance.
module tb_wri_red;
    logic       clk = 1'b0;
    logic       rst_n;

    logic [1:0] addr_a;
    logic       in_a;
    logic       rw_a;
    logic       out_a;

    logic [2:0] addr_b;
    logic [7:0] in_b;
    logic       rw_b;
    logic [7:0] out_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wri_red u_dut_a (
        .CLK   (clk),
        .RST_N (rst_n),
        .ADDR  (addr_a),
        .IN    (in_a),
        .RW    (rw_a),
        .OUT   (out_a)
    );

    wri_red #(
        .WIDTH (8),
        .DEPTH (8)
    ) u_dut_b (
        .CLK   (clk),
        .RST_N (rst_n),
        .ADDR  (addr_b),
        .IN    (in_b),
        .RW    (rw_b),
        .OUT   (out_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic rw, input logic [1:0] a, input logic d);
        @(negedge clk);
        rw_a   = rw;
        addr_a = a;
        in_a   = d;
        step();
    endtask

    task automatic op_b(input logic rw, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        rw_b   = rw;
        addr_b = a;
        in_b   = d;
        step();
    endtask

    initial begin
        // Reset with X on the data/control inputs; nothing may leak into state.
        rst_n  = 1'b0;
        rw_a   = 1'bx;
        addr_a = 2'bxx;
        in_a   = 1'bx;
        rw_b   = 1'bx;
        addr_b = 3'bxxx;
        in_b   = 8'hxx;
        step();
        step();
        chk("reset_out_a", {7'd0, out_a}, 8'h00);
        chk("reset_out_b", out_b, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        rw_b  = 1'b0;
        addr_b = 3'd0;
        in_b  = 8'h00;
        rw_a  = 1'b0;
        addr_a = 2'd0;
        in_a  = 1'b0;

        // 1. all entries read back zero after reset
        for (int i = 0; i < 4; i++) begin
            op_a(1'b0, 2'(i), 1'b0);
            chk($sformatf("reset_rd%0d", i), {7'd0, out_a}, 8'h00);
        end

        // 2. entry 0: OUT holds across the write edge, then shows the data
        op_a(1'b1, 2'd0, 1'b1);
        chk("wr0_out_hold", {7'd0, out_a}, 8'h00);
        op_a(1'b0, 2'd0, 1'b0);
        chk("rd0_after_wr", {7'd0, out_a}, 8'h01);

        // 3. entry 1 independent from entry 0
        op_a(1'b1, 2'd1, 1'b0);
        chk("wr1_out_hold", {7'd0, out_a}, 8'h01);
        op_a(1'b0, 2'd1, 1'b1);
        chk("rd1", {7'd0, out_a}, 8'h00);
        op_a(1'b0, 2'd0, 1'b0);
        chk("rd0_indep", {7'd0, out_a}, 8'h01);

        // 4. pattern 1,0,1,1 then reverse read
        op_a(1'b1, 2'd0, 1'b1);
        op_a(1'b1, 2'd1, 1'b0);
        op_a(1'b1, 2'd2, 1'b1);
        op_a(1'b1, 2'd3, 1'b1);
        op_a(1'b0, 2'd3, 1'b0);
        chk("pat_rd3", {7'd0, out_a}, 8'h01);
        op_a(1'b0, 2'd2, 1'b0);
        chk("pat_rd2", {7'd0, out_a}, 8'h01);
        op_a(1'b0, 2'd1, 1'b0);
        chk("pat_rd1", {7'd0, out_a}, 8'h00);
        op_a(1'b0, 2'd0, 1'b0);
        chk("pat_rd0", {7'd0, out_a}, 8'h01);

        // 5. reset edge wins over a write
        @(negedge clk);
        rst_n  = 1'b0;
        rw_a   = 1'b1;
        addr_a = 2'd2;
        in_a   = 1'b1;
        step();
        chk("mid_rst_out", {7'd0, out_a}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rw_a  = 1'b0;
        op_a(1'b0, 2'd2, 1'b0);
        chk("mid_rst_rd2", {7'd0, out_a}, 8'h00);
        op_a(1'b0, 2'd0, 1'b0);
        chk("mid_rst_rd0", {7'd0, out_a}, 8'h00);
        op_a(1'b0, 2'd3, 1'b0);
        chk("mid_rst_rd3", {7'd0, out_a}, 8'h00);
        // first edge after reset behaves normally
        op_a(1'b1, 2'd3, 1'b1);
        op_a(1'b0, 2'd3, 1'b0);
        chk("post_rst_wr_rd3", {7'd0, out_a}, 8'h01);

        // 6. wide/deep configuration
        op_b(1'b1, 3'd7, 8'hA5);
        chk("b_wr7_hold", out_b, 8'h00);
        op_b(1'b0, 3'd7, 8'h00);
        chk("b_rd7", out_b, 8'hA5);
        op_b(1'b0, 3'd6, 8'h00);
        chk("b_rd6", out_b, 8'h00);
        op_b(1'b1, 3'd0, 8'h3C);
        chk("b_wr0_hold", out_b, 8'h00);
        op_b(1'b0, 3'd0, 8'h00);
        chk("b_rd0", out_b, 8'h3C);
        op_b(1'b0, 3'd7, 8'h00);
        chk("b_rd7_again", out_b, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
